systolic_mm_engine: RTL
=======================

Name: systolic_mm_engine

Overview:
Parametrised output-stationary systolic matrix-multiply engine computing C[N×M] = A[N×K]·B[K×M] for run-time K up to K_MAX.
- Operands stream in one K-slice per beat over a valid/ready handshake; skewing is done internally.
- Results drain one C row per beat over a valid/ready output.
- Sits between the RISC-V load/store front end and the result write-back buffer.
- Successor to the fixed 4×4/32-bit array: adds rectangular grid, narrow operands with wide accumulators, signed/unsigned mode, backpressure and programmable K.

Parameters:
N, 4, PE grid rows (rows of A and C)
M, 4, PE grid columns (columns of B and C)
K_MAX, 16, maximum inner dimension
DW, 8, operand width
AW, 32, accumulator and result width (AW ≥ 2*DW + clog2(K_MAX))
KW, $clog2(K_MAX+1), derived width of k_len

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin job; sampled only in IDLE
k_len  in  KW  inner dimension K, latched on start
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; latched on start
in_valid  in  1  operand beat valid
in_ready  out  1  engine accepts operand beat
a_vec  in  N*DW  column k of A; element i at [i*DW +: DW]
b_vec  in  M*DW  row k of B; element j at [j*DW +: DW]
out_valid  out  1  result row valid
out_ready  in  1  downstream accepts result row
out_row  out  M*AW  row r of C; element j at [j*AW +: AW]
out_row_idx  out  $clog2(N)  index r of out_row
busy  out  1  high in any state except IDLE
done  out  1  single-cycle pulse after last row accepted

Behaviour:
- Reset: all PEs, skew registers and counters cleared; state IDLE.
- Reset values: in_ready=0, out_valid=0, out_row=0, out_row_idx=0, busy=0, done=0.
- Reset mid-job aborts immediately; no done pulse.
- FSM: IDLE → FEED → FLUSH → DRAIN → IDLE.
- IDLE:
  - On start, latch k_len and signed_mode and clear all accumulators.
  - k_len in 1..K_MAX → FEED.
  - k_len=0 → DRAIN directly; all results are zero.
  - k_len>K_MAX → clamp to K_MAX.
- FEED:
  - in_ready=1. A beat is accepted when in_valid && in_ready; beat counter increments.
  - Row i of A enters the grid delayed i cycles; column j of B is delayed j cycles. Each operand carries a valid tag.
  - Cycles with no accepted beat inject valid=0 bubbles; the array keeps shifting every cycle (no stall).
  - On acceptance of beat k_len-1, in_ready drops the next cycle → FLUSH.
- FLUSH: counter runs N+M cycles so PE(N-1,M-1) absorbs the last operand → DRAIN.
- PE(i,j):
  - Registered MAC: acc += ext(a)*ext(b) only when both tags valid.
  - Operands pass right and down with a 1-cycle register each.
  - ext = sign-extend or zero-extend per latched signed_mode.
  - Accumulation wraps modulo 2^AW.
- DRAIN:
  - out_valid=1 with out_row = C row r, r from 0 to N-1.
  - Row and index are held stable while out_valid && !out_ready.
  - r advances on handshake.
  - On acceptance of row N-1: out_valid=0, done=1 for one cycle, state IDLE.
- start outside IDLE is ignored. Inputs are ignored while in_ready=0.
- Minimum job latency: start → first out_valid = 1 + k_len + N + M cycles with in_valid held high.

Optional Feature:
SYSTOLIC_SAT_EN
- Defined: each accumulate saturates to the AW-bit range. Signed mode uses [-2^(AW-1), 2^(AW-1)-1]; unsigned uses [0, 2^AW-1].
- Undefined: plain modulo-2^AW wrap with no saturation logic.

Decomposition:
- Package systolic_pkg holds:
  - state_e enum (IDLE, FEED, FLUSH, DRAIN).
  - Default-parameter localparams.
  - Function ext_operand(data, signed_mode) returning a 2*DW-wide value.
- One sub-module, systolic_pe: operand and tag pass-through registers, MAC, clear input, optional saturation.
- Skew delay lines and the FSM stay in the top level.

Test Plan:
- Identity: N=M=4, K=4, unsigned, A=I, B[k][j]=k*4+j → rows read 0,1,2,3 / 4,5,6,7 / 8,9,10,11 / 12,13,14,15; done pulses once.
- Signed: K=2, all A=8'hFF (-1), all B=8'h02, signed_mode=1 → every element 32'hFFFFFFFC (-4); same data with signed_mode=0 → every element 1020.
- Bubbles plus backpressure:
  - K=16, in_valid toggling 1/0, out_ready low for 3 cycles per row.
  - Results match the golden model; out_row/out_row_idx stable while stalled.
- k_len=0 → four zero rows then done; k_len=20 with K_MAX=16 → exactly 16 beats accepted.
- Overflow: AW=16, K=2, A=B=8'hFF unsigned → 2*65025 = 130050.
  - Without SYSTOLIC_SAT_EN: 130050 mod 65536 = 64514.
  - With SYSTOLIC_SAT_EN: 65535.
- Reset asserted mid-FEED:
  - Reset values on the next clock edge.
  - A subsequent start with K=1, a=2, b=3 gives 6 in every element.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types, default sizes and operand-extension helper for the systolic matrix-multiply engine.
// Build option SYSTOLIC_SAT_EN (see systolic_pe) selects saturating accumulation.
package systolic_pkg;

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_e;

  localparam int DEF_N     = 4;
  localparam int DEF_M     = 4;
  localparam int DEF_K_MAX = 16;
  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 32;
  // Widest operand the helper below can extend; engines must use DW <= DW_MAX.
  localparam int DW_MAX    = 16;

  // Extends the low dw bits of data to 2*dw bits (sign or zero per signed_mode); higher bits repeat the fill.
  function automatic logic [2*DW_MAX-1:0] ext_operand(input logic [DW_MAX-1:0] data,
                                                      input int dw,
                                                      input logic signed_mode);
    logic fill;
    fill = 1'b0;
    for (int b = 0; b < DW_MAX; b++) begin
      if (b == dw - 1) fill = signed_mode & data[b];
    end
    for (int b = 0; b < DW_MAX; b++) begin
      ext_operand[b] = (b < dw) ? data[b] : fill;
    end
    for (int b = DW_MAX; b < 2*DW_MAX; b++) begin
      ext_operand[b] = fill;
    end
  endfunction

endpackage

// File: rtl/systolic_mm_engine_if.sv
// Operand-in / result-out stream bundle of the systolic engine; the engine uses the slave modport.
// Both streams are valid/ready: a beat transfers on a rising clock edge with valid && ready high; the sender holds data stable while valid && !ready.
interface systolic_mm_engine_if
  import systolic_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int M  = DEF_M,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] a_vec;
  logic [M*DW-1:0] b_vec;
  logic            out_valid;
  logic            out_ready;
  logic [M*AW-1:0] out_row;
  logic [RW-1:0]   out_row_idx;

  modport master (output in_valid, a_vec, b_vec, out_ready,
                  input  in_ready, out_valid, out_row, out_row_idx);
  modport slave  (input  in_valid, a_vec, b_vec, out_ready,
                  output in_ready, out_valid, out_row, out_row_idx);
endinterface

// File: rtl/systolic_pe.sv
// One processing element: registered operand/tag pass-through plus a MAC that fires only on valid tags.
// With SYSTOLIC_SAT_EN defined the accumulator clamps to the AW-bit range; otherwise it wraps.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          signed_i,
  input  logic [DW-1:0] a_i,
  input  logic          a_vld_i,
  input  logic [DW-1:0] b_i,
  input  logic          b_vld_i,
  output logic [DW-1:0] a_o,
  output logic          a_vld_o,
  output logic [DW-1:0] b_o,
  output logic          b_vld_o,
  output logic [AW-1:0] acc_o
);
  logic [DW-1:0]       a_q, b_q;
  logic                a_vld_q, b_vld_q;
  logic [AW-1:0]       acc_q, acc_d;
  logic [2*DW_MAX-1:0] ea_w, eb_w;
  logic [2*DW-1:0]     prod;

  always_comb begin
    ea_w = ext_operand(DW_MAX'(a_i), DW, signed_i);
    eb_w = ext_operand(DW_MAX'(b_i), DW, signed_i);
    // Low 2*DW bits of the product are exact for both signed and unsigned operands.
    prod = ea_w[2*DW-1:0] * eb_w[2*DW-1:0];
  end

  if (DW < DW_MAX) begin : g_ext_hi
    logic unused_ext_hi;
    assign unused_ext_hi = ^{ea_w[2*DW_MAX-1:2*DW], eb_w[2*DW_MAX-1:2*DW]};
  end

`ifdef SYSTOLIC_SAT_EN
  localparam int PW = AW + 2;
  localparam logic signed [PW-1:0] SMAX = {3'b000, {(AW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {3'b111, {(AW-1){1'b0}}};
  localparam logic signed [PW-1:0] UMAX = {2'b00, {AW{1'b1}}};
  logic signed [PW-1:0] sum;

  always_comb begin
    sum = $signed({{2{signed_i & acc_q[AW-1]}}, acc_q})
        + $signed({{(PW-2*DW){signed_i & prod[2*DW-1]}}, prod});
    acc_d = sum[AW-1:0];
    if (signed_i) begin
      if (sum > SMAX)      acc_d = {1'b0, {(AW-1){1'b1}}};
      else if (sum < SMIN) acc_d = {1'b1, {(AW-1){1'b0}}};
    end else if (sum > UMAX) begin
      acc_d = {AW{1'b1}};
    end
  end
`else
  always_comb begin
    acc_d = acc_q + {{(AW-2*DW){signed_i & prod[2*DW-1]}}, prod};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_q     <= a_i;
      b_q     <= b_i;
      a_vld_q <= a_vld_i;
      b_vld_q <= b_vld_i;
      if (clear_i)                acc_q <= '0;
      else if (a_vld_i && b_vld_i) acc_q <= acc_d;
    end
  end

  assign a_o     = a_q;
  assign a_vld_o = a_vld_q;
  assign b_o     = b_q;
  assign b_vld_o = b_vld_q;
  assign acc_o   = acc_q;
endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic engine C[NxM] = A[NxK]*B[KxM]: input skew lines, PE grid and job FSM.
// Accumulation mode follows the SYSTOLIC_SAT_EN build option inside systolic_pe.
module systolic_mm_engine
  import systolic_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int K_MAX = DEF_K_MAX,
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int KW    = $clog2(K_MAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 signed_mode,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state_o,
  systolic_mm_engine_if.slave  bus
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = $clog2(N + M);

  state_e        state_q;
  logic [KW-1:0] k_len_q, beat_q, k_eff;
  logic [FW-1:0] flush_q;
  logic [RW-1:0] row_q;
  logic          signed_q, in_ready_q, out_valid_q, done_q;
  logic          fire, clear;

  logic [DW-1:0] a_h  [N][M+1];
  logic          av_h [N][M+1];
  logic [DW-1:0] b_v  [N+1][M];
  logic          bv_v [N+1][M];
  logic [AW-1:0] acc  [N][M];
  logic [M*AW-1:0] out_row_w;
  logic          unused_edges;

  assign fire  = bus.in_valid && in_ready_q;
  assign clear = (state_q == IDLE) && start;
  assign k_eff = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;

  // Row i of A sees i extra register stages (column j of B sees j) so each operand pair meets at its PE.
  for (genvar i = 0; i < N; i++) begin : g_askew
    logic [DW-1:0] d_q [i+1];
    logic [i:0]    v_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) d_q[s] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= bus.a_vec[i*DW +: DW];
        v_q[0] <= fire;
        for (int s = 1; s <= i; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end
    assign a_h[i][0]  = d_q[i];
    assign av_h[i][0] = v_q[i];
  end

  for (genvar j = 0; j < M; j++) begin : g_bskew
    logic [DW-1:0] d_q [j+1];
    logic [j:0]    v_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= j; s++) d_q[s] <= '0;
        v_q <= '0;
      end else begin
        d_q[0] <= bus.b_vec[j*DW +: DW];
        v_q[0] <= fire;
        for (int s = 1; s <= j; s++) begin
          d_q[s] <= d_q[s-1];
          v_q[s] <= v_q[s-1];
        end
      end
    end
    assign b_v[0][j]  = d_q[j];
    assign bv_v[0][j] = v_q[j];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < M; j++) begin : g_col
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear),
        .signed_i(signed_q),
        .a_i     (a_h[i][j]),
        .a_vld_i (av_h[i][j]),
        .b_i     (b_v[i][j]),
        .b_vld_i (bv_v[i][j]),
        .a_o     (a_h[i][j+1]),
        .a_vld_o (av_h[i][j+1]),
        .b_o     (b_v[i+1][j]),
        .b_vld_o (bv_v[i+1][j]),
        .acc_o   (acc[i][j])
      );
    end
  end

  always_comb begin
    unused_edges = 1'b0;
    for (int i = 0; i < N; i++) unused_edges = unused_edges ^ (^a_h[i][M]) ^ av_h[i][M];
    for (int j = 0; j < M; j++) unused_edges = unused_edges ^ (^b_v[N][j]) ^ bv_v[N][j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      signed_q    <= 1'b0;
      beat_q      <= '0;
      flush_q     <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          k_len_q  <= k_eff;
          signed_q <= signed_mode;
          beat_q   <= '0;
          row_q    <= '0;
          if (k_eff == '0) begin
            state_q     <= DRAIN;
            out_valid_q <= 1'b1;
          end else begin
            state_q    <= FEED;
            in_ready_q <= 1'b1;
          end
        end
        FEED: if (fire) begin
          if (beat_q + KW'(1) == k_len_q) begin
            in_ready_q <= 1'b0;
            flush_q    <= '0;
            state_q    <= FLUSH;
          end else begin
            beat_q <= beat_q + KW'(1);
          end
        end
        // N+M cycles lets the last operand pair reach PE(N-1,M-1) and accumulate.
        FLUSH: if (flush_q == FW'(N + M - 1)) begin
          state_q     <= DRAIN;
          out_valid_q <= 1'b1;
        end else begin
          flush_q <= flush_q + FW'(1);
        end
        DRAIN: if (bus.out_ready) begin
          if (row_q == RW'(N - 1)) begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            row_q       <= '0;
            state_q     <= IDLE;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_row_w = '0;
    for (int j = 0; j < M; j++) out_row_w[j*AW +: AW] = acc[row_q][j];
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_w;
  assign bus.out_row_idx = row_q;
  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign dbg_state_o     = state_q;
endmodule
